// File: rtl/dijkstra_axil_slave_regs.sv
// AXI4-Lite register slave for the Dijkstra path engine.
// Registers: 0x0 CTRL (b0 start, b1 ie), 0x4 NODES, 0x8 STATUS (b0 done, b1 busy, b2 err),
// 0xC RESULT. One outstanding write and one outstanding read; the channels are independent.
module dijkstra_axil_slave_regs #(
   parameter int ADDR_W = 4,
   parameter int NODE_W = 8,
   parameter int LEN_W  = 16
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [ADDR_W-1:0] S_AXI_AWADDR,
   input  logic [2:0]        S_AXI_AWPROT,
   input  logic              S_AXI_AWVALID,
   output logic              S_AXI_AWREADY,
   input  logic [31:0]       S_AXI_WDATA,
   input  logic [3:0]        S_AXI_WSTRB,
   input  logic              S_AXI_WVALID,
   output logic              S_AXI_WREADY,
   output logic [1:0]        S_AXI_BRESP,
   output logic              S_AXI_BVALID,
   input  logic              S_AXI_BREADY,
   input  logic [ADDR_W-1:0] S_AXI_ARADDR,
   input  logic [2:0]        S_AXI_ARPROT,
   input  logic              S_AXI_ARVALID,
   output logic              S_AXI_ARREADY,
   output logic [31:0]       S_AXI_RDATA,
   output logic [1:0]        S_AXI_RRESP,
   output logic              S_AXI_RVALID,
   input  logic              S_AXI_RREADY,
   output logic              start_o,
   output logic [NODE_W-1:0] src_node_o,
   output logic [NODE_W-1:0] dst_node_o,
   input  logic              busy_i,
   input  logic              done_i,
   input  logic [LEN_W-1:0]  path_len_i,
   output logic              irq_o
);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_NODES  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_RESULT = 2'd3;

   // Handshake-enable flag keeps every READY low while reset is asserted.
   logic              en_q;
   logic              aw_held_q, aw_held_d;
   logic [1:0]        aw_idx_q, aw_idx_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       w_data_q, w_data_d;
   logic [3:0]        w_strb_q, w_strb_d;
   logic              bvalid_q, bvalid_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ie_q, ie_d;
   logic [31:0]       nodes_q, nodes_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [LEN_W-1:0]  result_q, result_d;
   logic              start_q, start_d;

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [31:0]       rd_mux;
   logic [31:0]       result_ext;
   logic              unused_ok;

   assign S_AXI_AWREADY = en_q & ~aw_held_q & ~bvalid_q;
   assign S_AXI_WREADY  = en_q & ~w_held_q & ~bvalid_q;
   assign S_AXI_ARREADY = en_q & ~rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   // A write commits on the edge after both address and data have been captured.
   assign commit = aw_held_q & w_held_q;

   assign start_o    = start_q;
   assign src_node_o = nodes_q[NODE_W-1:0];
   assign dst_node_o = nodes_q[16 +: NODE_W];
   assign irq_o      = done_q & ie_q;

   // Protection bits, byte-offset bits and any address bits above [3:2] carry no meaning here.
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // NODES is byte-writable: each lane updates only when its strobe is set.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nodes_lane
         assign nodes_d[8*gi +: 8] = (commit && aw_idx_q == REG_NODES && w_strb_q[gi])
                                     ? w_data_q[8*gi +: 8] : nodes_q[8*gi +: 8];
      end
   endgenerate

   // Write-channel capture, commit and response tracking.
   always_comb begin
      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
      end else begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
         end
      end
      if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
   end

   // Control/status register updates; an engine done pulse outranks a same-cycle W1C.
   always_comb begin
      ie_d     = ie_q;
      done_d   = done_q;
      err_d    = err_q;
      result_d = result_q;
      start_d  = 1'b0;
      if (commit) begin
         case (aw_idx_q)
            REG_CTRL: begin
               if (w_strb_q[0]) begin
                  ie_d = w_data_q[1];
                  if (w_data_q[0]) begin
                     if (busy_i) begin
                        err_d = 1'b1;
                     end else begin
                        start_d = 1'b1;
                     end
                  end
               end
            end
            REG_STATUS: begin
               if (w_strb_q[0]) begin
                  if (w_data_q[0]) done_d = 1'b0;
                  if (w_data_q[2]) err_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (done_i) begin
         done_d   = 1'b1;
         result_d = path_len_i;
      end
   end

   // Read data mux; reads see register state before any write committing on the same edge.
   always_comb begin
      result_ext                = '0;
      result_ext[LEN_W-1:0]     = result_q;
      rd_mux                    = '0;
      case (S_AXI_ARADDR[3:2])
         REG_CTRL:   rd_mux = {30'd0, ie_q, 1'b0};
         REG_NODES:  rd_mux = nodes_q;
         REG_STATUS: rd_mux = {29'd0, err_q, busy_i, done_q};
         REG_RESULT: rd_mux = result_ext;
         default:    rd_mux = '0;
      endcase
   end

   // Read-channel response register: data is held stable until the master takes it.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_mux;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   // State registers; reset abandons any partially captured or pending transfer.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         en_q      <= 1'b0;
         aw_held_q <= 1'b0;
         aw_idx_q  <= 2'd0;
         w_held_q  <= 1'b0;
         w_data_q  <= 32'd0;
         w_strb_q  <= 4'd0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         ie_q      <= 1'b0;
         nodes_q   <= 32'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         result_q  <= '0;
         start_q   <= 1'b0;
      end else begin
         en_q      <= 1'b1;
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         ie_q      <= ie_d;
         nodes_q   <= nodes_d;
         done_q    <= done_d;
         err_q     <= err_d;
         result_q  <= result_d;
         start_q   <= start_d;
      end
   end

endmodule

// File: tb/tb_dijkstra_axil_slave_regs.sv
// Directed bench for dijkstra_axil_slave_regs: register access, strobes, channel ordering,
// back-pressure, engine start/done handshake, error and interrupt behaviour.
module tb_dijkstra_axil_slave_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        start_o, busy_i, done_i, irq_o;
   logic [7:0]  src_node, dst_node;
   logic [15:0] path_len;

   int          vectors     = 0;
   int          miscompares = 0;
   int          start_cnt   = 0;
   int          start_before;
   logic        start_at_b;
   logic        hold_ok;
   logic [31:0] rd;

   always #5 clk = ~clk;

   // Count cycles with start_o high, sampled mid-cycle.
   always @(negedge clk) if (start_o) start_cnt++;

   dijkstra_axil_slave_regs #(.ADDR_W(4), .NODE_W(8), .LEN_W(16)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .start_o(start_o), .src_node_o(src_node), .dst_node_o(dst_node),
      .busy_i(busy_i), .done_i(done_i), .path_len_i(path_len), .irq_o(irq_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Full write transaction; called and returning on a negative clock edge.
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int   n;
      logic aw_hs, w_hs;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clk);
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      start_at_b = start_o;
      check("wr_bvalid", {31'd0, bvalid}, 32'd1);
      check("wr_bresp", {30'd0, bresp}, 32'd0);
      @(negedge clk);
      bready = 1'b0;
   endtask

   // Full read transaction; called and returning on a negative clock edge.
   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int n;
      araddr = a; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rd_rvalid", {31'd0, rvalid}, 32'd1);
      check("rd_rresp", {30'd0, rresp}, 32'd0);
      d = rdata;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      awaddr = 4'd0; araddr = 4'd0; awprot = 3'd0; arprot = 3'd0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'd0; wstrb = 4'd0; busy_i = 1'b0; done_i = 1'b0; path_len = 16'd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_wready", {31'd0, wready}, 32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_start_irq", {30'd0, start_o, irq_o}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      axi_read(4'h0, rd); check("rst_ctrl", rd, 32'h0);
      axi_read(4'h4, rd); check("rst_nodes", rd, 32'h0);
      axi_read(4'h8, rd); check("rst_status", rd, 32'h0);
      axi_read(4'hC, rd); check("rst_result", rd, 32'h0);

      // 1: full NODES write
      axi_write(4'h4, 32'h0005_0003, 4'hF);
      axi_read(4'h4, rd); check("t1_nodes", rd, 32'h0005_0003);
      check("t1_src", {24'd0, src_node}, 32'd3);
      check("t1_dst", {24'd0, dst_node}, 32'd5);

      // 2: byte-strobe write
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
      axi_write(4'h4, 32'h1234_5678, 4'h2);
      axi_read(4'h4, rd); check("t2_strb", rd, 32'hFFFF_56FF);

      // 3: W leads AW by 3 cycles; 4: BREADY held low for 10 cycles
      wdata = 32'hA5A5_0102; wstrb = 4'hF; wvalid = 1'b1;
      check("t3_wready_first", {31'd0, wready}, 32'd1);
      @(negedge clk); wvalid = 1'b0;
      check("t3_wready_held", {31'd0, wready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("t3_no_early_b", {31'd0, bvalid}, 32'd0);
      awaddr = 4'h4; awvalid = 1'b1;
      check("t3_awready", {31'd0, awready}, 32'd1);
      @(negedge clk); awvalid = 1'b0;
      check("t3_b_not_yet", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
      check("t3_bvalid", {31'd0, bvalid}, 32'd1);
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!(bvalid && !awready && !wready)) hold_ok = 1'b0;
         @(negedge clk);
      end
      check("t4_backpressure", {31'd0, hold_ok}, 32'd1);
      bready = 1'b1;
      @(negedge clk); bready = 1'b0;
      check("t4_b_done", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
      check("t3_single_b", {31'd0, bvalid}, 32'd0);
      axi_read(4'h4, rd); check("t3_nodes", rd, 32'hA5A5_0102);

      // 5: start, completion, interrupt, W1C
      start_before = start_cnt;
      axi_write(4'h0, 32'h3, 4'hF);
      check("t5_start_timing", {31'd0, start_at_b}, 32'd1);
      check("t5_start_count", start_cnt - start_before, 32'd1);
      axi_read(4'h0, rd); check("t5_ctrl", rd, 32'h2);
      path_len = 16'h002A; done_i = 1'b1;
      @(negedge clk); done_i = 1'b0;
      check("t5_irq_set", {31'd0, irq_o}, 32'd1);
      axi_read(4'h8, rd); check("t5_status", rd, 32'h1);
      axi_read(4'hC, rd); check("t5_result", rd, 32'h2A);
      axi_write(4'h8, 32'h1, 4'hF);
      check("t5_irq_clr", {31'd0, irq_o}, 32'd0);
      axi_read(4'h8, rd); check("t5_status_clr", rd, 32'h0);

      // 6: start while busy -> error, no pulse
      busy_i = 1'b1;
      start_before = start_cnt;
      axi_write(4'h0, 32'h1, 4'hF);
      check("t6_no_start", {31'd0, start_at_b}, 32'd0);
      check("t6_start_count", start_cnt - start_before, 32'd0);
      axi_read(4'h8, rd); check("t6_status_err_busy", rd, 32'h6);
      busy_i = 1'b0;
      axi_write(4'h8, 32'h4, 4'hF);
      axi_read(4'h8, rd); check("t6_err_clr", rd, 32'h0);

      // 6: W1C of done on the same edge as done_i -> done survives
      axi_write(4'h0, 32'h2, 4'hF);
      path_len = 16'h0010; done_i = 1'b1;
      @(negedge clk); done_i = 1'b0;
      awaddr = 4'h8; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; path_len = 16'h0077; done_i = 1'b1;
      @(negedge clk);
      done_i = 1'b0;
      check("t6_race_bvalid", {31'd0, bvalid}, 32'd1);
      bready = 1'b1;
      @(negedge clk); bready = 1'b0;
      axi_read(4'h8, rd); check("t6_race_done", rd, 32'h1);
      axi_read(4'hC, rd); check("t6_race_result", rd, 32'h77);
      check("t6_race_irq", {31'd0, irq_o}, 32'd1);

      // RESULT is read-only, reserved CTRL bits read back as zero, byte offset ignored
      axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
      axi_read(4'hC, rd); check("ro_result", rd, 32'h77);
      axi_write(4'h0, 32'hFFFF_FFFE, 4'hF);
      axi_read(4'h0, rd); check("ctrl_reserved", rd, 32'h2);
      axi_read(4'h5, rd); check("addr_alias", rd, 32'hA5A5_0102);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
